// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM: the state register is the only flop, outputs decode from (state, op, zero).
// Optional INSN_COUNT_EN adds a retired-instruction counter output insn_count.
module multi_cycle_control_unit #(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter logic [1:0] RA_SEL  = 2'b00
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic [1:0] RegDst,
  output logic       RegWre,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc
`ifdef INSN_COUNT_EN
  , output logic [31:0] insn_count
`endif
);

  localparam logic [5:0] opAdd  = 6'b000000;
  localparam logic [5:0] opSub  = 6'b000001;
  localparam logic [5:0] opAddi = 6'b000010;
  localparam logic [5:0] opOr   = 6'b010000;
  localparam logic [5:0] opAnd  = 6'b010001;
  localparam logic [5:0] opOri  = 6'b010010;
  localparam logic [5:0] opSll  = 6'b011000;
  localparam logic [5:0] opSlt  = 6'b100110;
  localparam logic [5:0] opSw   = 6'b110000;
  localparam logic [5:0] opLw   = 6'b110001;
  localparam logic [5:0] opBeq  = 6'b110100;
  localparam logic [5:0] opJ    = 6'b111000;
  localparam logic [5:0] opJr   = 6'b111001;
  localparam logic [5:0] opJal  = 6'b111010;

  typedef enum logic [2:0] {
    sIF     = 3'b000,
    sID     = 3'b001,
    sEXE_LS = 3'b010,
    sMEM    = 3'b011,
    sWB_LD  = 3'b100,
    sEXE_BR = 3'b101,
    sEXE_AL = 3'b110,
    sWB_AL  = 3'b111
  } stateT;

  stateT curState, nextState;
  logic  isRType, isAluOp;

  assign isRType = op inside {opAdd, opSub, opOr, opAnd, opSll, opSlt};
  assign isAluOp = isRType || (op == opAddi) || (op == opOri);

  always_comb begin
    nextState = sIF;
    case (curState)
      sIF: nextState = sID;
      sID: begin
        if (op == HALT_OP)                    nextState = sID;
        else if (isAluOp)                     nextState = sEXE_AL;
        else if (op == opBeq)                 nextState = sEXE_BR;
        else if (op == opLw || op == opSw)    nextState = sEXE_LS;
        else                                  nextState = sIF;
      end
      sEXE_AL: nextState = sWB_AL;
      sEXE_LS: nextState = sMEM;
      sMEM:    nextState = (op == opLw) ? sWB_LD : sIF;
      default: nextState = sIF;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) curState <= sIF;
    else       curState <= nextState;
  end

  assign state    = curState;
  assign InsMemRW = 1'b1;

  // Enables are gated by Reset so an aborted instruction cannot commit anything.
  assign IRWre  = !Reset && (curState == sIF);
  assign PCWre  = !Reset && (nextState == sIF);
  assign RegWre = !Reset && ((curState == sWB_AL) || (curState == sWB_LD) ||
                             (curState == sID && op == opJal));
  assign mRD    = !Reset && (curState == sMEM) && (op == opLw);
  assign mWR    = !Reset && (curState == sMEM) && (op == opSw);

  always_comb begin
    ALUOp     = 3'b000;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b1;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    if (curState != sIF) begin
      ALUSrcA   = (op == opSll);
      ALUSrcB   = op inside {opAddi, opOri, opLw, opSw};
      ExtSel    = (op != opOri);
      WrRegDSrc = (op != opJal);
      DBDataSrc = (op == opLw);
      case (op)
        opSub, opBeq: ALUOp = 3'b001;
        opSll:        ALUOp = 3'b010;
        opOr, opOri:  ALUOp = 3'b011;
        opAnd:        ALUOp = 3'b100;
        opSlt:        ALUOp = 3'b110;
        default:      ALUOp = 3'b000;
      endcase
      if (isRType)                                        RegDst = 2'b10;
      else if (op == opAddi || op == opOri || op == opLw) RegDst = 2'b01;
      else if (op == opJal)                               RegDst = RA_SEL;
      if (op == opJr)                                     PCSrc = 2'b10;
      else if (op == opJ || op == opJal)                  PCSrc = 2'b11;
      else if (op == opBeq && curState == sEXE_BR && zero) PCSrc = 2'b01;
    end
  end

`ifdef INSN_COUNT_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)      insn_count <= 32'd0;
    else if (PCWre) insn_count <= insn_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-instruction step model, directed plan items, then random ops.
module tb_multi_cycle_control_unit;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, OR_ = 6'b010000;
  localparam logic [5:0] AND_ = 6'b010001, ORI = 6'b010010, SLL = 6'b011000, SLT = 6'b100110;
  localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100, J = 6'b111000;
  localparam logic [5:0] JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

  typedef enum int {kAlu, kLw, kSw, kBeq, kJmp, kHalt} kindT;

  logic CLK = 1'b0;
  logic Reset, zero;
  logic [5:0] op;
  logic [2:0] state, ALUOp;
  logic PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [1:0] RegDst, PCSrc;
`ifdef INSN_COUNT_EN
  logic [31:0] insn_count;
`endif

  multi_cycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst),
    .RegWre(RegWre), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc)
`ifdef INSN_COUNT_EN
    , .insn_count(insn_count)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int step = 0;
  int unsigned mCount = 0;
  int stQ[$], pcQ[$], rwQ[$], expQ[$];
  logic [5:0] opTab[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t op=%b step=%0d: got %0h expected %0h", name, $time, op, step, act, exp);
    end
  endtask

  function automatic kindT kindOf(input logic [5:0] o);
    if (o == HALT) return kHalt;
    if (o inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT}) return kAlu;
    if (o == LW) return kLw;
    if (o == SW) return kSw;
    if (o == BEQ) return kBeq;
    return kJmp;
  endfunction

  // Index of the step that retires the instruction; halt never retires.
  function automatic int lastStep(input kindT k);
    case (k)
      kAlu: return 3;
      kLw:  return 4;
      kSw:  return 3;
      kBeq: return 2;
      kJmp: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int stateAt(input kindT k, input int s);
    if (s == 0) return 0;
    if (s == 1) return 1;
    case (k)
      kAlu:    return (s == 2) ? 6 : 7;
      kBeq:    return 5;
      kLw, kSw: return s;
      default: return 1;
    endcase
  endfunction

  function automatic bit expPCWre();
    return !Reset && (step == lastStep(kindOf(op)));
  endfunction

  task automatic compareAll();
    kindT k = kindOf(op);
    bit fetch = Reset || (step == 0);
    int eAlu, eDst, ePcs;
    chk("state", state, Reset ? 0 : stateAt(k, step));
    chk("IRWre", IRWre, !Reset && step == 0);
    chk("PCWre", PCWre, expPCWre());
    chk("RegWre", RegWre, !Reset && ((k == kAlu && step == 3) || (k == kLw && step == 4) ||
                                     (op == JAL && step == 1)));
    chk("mRD", mRD, !Reset && k == kLw && step == 3);
    chk("mWR", mWR, !Reset && k == kSw && step == 3);
    chk("InsMemRW", InsMemRW, 1);
    eAlu = (op inside {SUB, BEQ}) ? 1 : (op == SLL) ? 2 : (op inside {OR_, ORI}) ? 3 :
           (op == AND_) ? 4 : (op == SLT) ? 6 : 0;
    eDst = (op inside {ADD, SUB, OR_, AND_, SLL, SLT}) ? 2 : (op inside {ADDI, ORI, LW}) ? 1 : 0;
    ePcs = (op == JR) ? 2 : (op inside {J, JAL}) ? 3 : (op == BEQ && step == 2 && zero) ? 1 : 0;
    chk("ALUOp", ALUOp, fetch ? 0 : eAlu);
    chk("ALUSrcA", ALUSrcA, !fetch && op == SLL);
    chk("ALUSrcB", ALUSrcB, !fetch && (op inside {ADDI, ORI, LW, SW}));
    chk("ExtSel", ExtSel, !fetch && op != ORI);
    chk("RegDst", RegDst, fetch ? 0 : eDst);
    chk("WrRegDSrc", WrRegDSrc, fetch || op != JAL);
    chk("DBDataSrc", DBDataSrc, !fetch && op == LW);
    chk("PCSrc", PCSrc, fetch ? 0 : ePcs);
`ifdef INSN_COUNT_EN
    chk("insn_count", insn_count, Reset ? 0 : mCount);
`endif
  endtask

  task automatic advance();
    kindT k = kindOf(op);
    if (Reset) begin
      step = 0;
      mCount = 0;
    end else begin
      if (expPCWre()) mCount++;
      if (step == lastStep(k)) step = 0;
      else if (k != kHalt || step == 0) step++;
    end
  endtask

  task automatic tick();
    #1;
    compareAll();
    stQ.push_back(int'(state));
    pcQ.push_back(int'(PCWre));
    rwQ.push_back(int'(RegWre));
    advance();
    @(negedge CLK);
  endtask

  task automatic clearQ();
    stQ.delete(); pcQ.delete(); rwQ.delete();
  endtask

  task automatic runInsn(input logic [5:0] o, input logic z, input bit randZ);
    op = o;
    for (int c = 0; c < 12; c++) begin
      zero = randZ ? 1'($urandom_range(0, 1)) : z;
      tick();
      if (step == 0) break;
    end
  endtask

  task automatic resetCycles(input int n);
    Reset = 1'b1;
    repeat (n) tick();
    Reset = 1'b0;
  endtask

  task automatic expectQ(input string name, input int got[$]);
    chk({name, "_len"}, got.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < got.size(); i++)
      chk(name, got[i], expQ[i]);
  endtask

  initial begin
    opTab = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SW, LW, BEQ, J, JR, JAL, HALT};
    Reset = 1'b1; op = ADD; zero = 1'b0;
    @(negedge CLK);
    resetCycles(2);

    clearQ(); runInsn(ADD, 1'b0, 1'b1);
    expQ = {0, 1, 6, 7}; expectQ("add_states", stQ);
    expQ = {0, 0, 0, 1}; expectQ("add_regwre", rwQ);
    expQ = {0, 0, 0, 1}; expectQ("add_pcwre", pcQ);

    clearQ(); runInsn(LW, 1'b0, 1'b1);
    expQ = {0, 1, 2, 3, 4}; expectQ("lw_states", stQ);
    expQ = {0, 0, 0, 0, 1}; expectQ("lw_regwre", rwQ);

    clearQ(); op = BEQ; zero = 1'b1; tick(); tick();
    #1 chk("beq_z1_pcsrc", PCSrc, 2'b01); chk("beq_z1_pcwre", PCWre, 1); chk("beq_z1_state", state, 3'b101);
    tick();

    clearQ(); runInsn(HALT, 1'b0, 1'b1);
    for (int i = 1; i < stQ.size(); i++) begin
      chk("halt_state", stQ[i], 1);
      chk("halt_pcwre", pcQ[i], 0);
    end
`ifdef INSN_COUNT_EN
    chk("count_after_halt", insn_count, 3);
`endif
    resetCycles(1);
    #1 chk("state_after_reset", state, 0); chk("irwre_after_reset", IRWre, 1);
`ifdef INSN_COUNT_EN
    chk("count_after_reset", insn_count, 0);
`endif

    op = BEQ; zero = 1'b0; tick(); tick();
    #1 chk("beq_z0_pcsrc", PCSrc, 2'b00); chk("beq_z0_pcwre", PCWre, 1);
    tick();

    clearQ(); op = JAL; tick();
    #1 chk("jal_regwre", RegWre, 1); chk("jal_regdst", RegDst, 2'b00); chk("jal_wrsrc", WrRegDSrc, 0);
    chk("jal_pcsrc", PCSrc, 2'b11); chk("jal_pcwre", PCWre, 1);
    tick();
    #1 chk("jal_next_state", state, 0);

    clearQ(); runInsn(6'b101010, 1'b0, 1'b1);
    expQ = {0, 1}; expectQ("nop_states", stQ);
    expQ = {0, 0}; expectQ("nop_regwre", rwQ);

    // Abort a store while it is in the memory state.
    op = SW; zero = 1'b0;
    repeat (3) tick();
    #1 chk("sw_mwr_before", mWR, 1);
    #2 Reset = 1'b1;
    #1 chk("sw_mwr_abort", mWR, 0); chk("sw_state_abort", state, 0);
    compareAll();
    advance();
    @(negedge CLK);
    tick();
    Reset = 1'b0;

    for (int n = 0; n < 200; n++) begin
      int r = $urandom_range(0, 17);
      logic [5:0] o = (r < 15) ? opTab[r] : 6'($urandom_range(0, 63));
      runInsn(o, 1'b0, 1'b1);
      if (kindOf(o) == kHalt) resetCycles(1 + $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
